// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset PC, NOP filler and PC step.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/inst_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load captures a new entry, clr drops valid, otherwise holds.
// One-cycle latency; the owner decides load/clr from decode back-pressure.
module if_id_reg #(
  parameter int          W   = 32,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] pc_plus4_in,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus4
);

  logic         valid_q, valid_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pc_plus4_q, pc_plus4_d;

  // A flushed entry keeps its payload; only valid is dropped.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
    end else if (clr) begin
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= W'(NOP);
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC, next-PC mux and BOOT/RUN/HALT FSM feeding an IF/ID register; 1-cycle fetch latency,
// IF/ID holds while decode stalls. Misaligned-redirect trap is built only with IFETCH_MISALIGN_CHK_EN.
module inst_fetch_unit #(
  parameter int          n         = 32,
  parameter logic [31:0] RESET_PC  = rv_fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [n-1:0] imem_addr,
  input  logic [n-1:0] imem_rdata,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_pc,
  input  logic         halt_req,
  input  logic         id_ready,
  output logic         if_valid,
  output logic [n-1:0] if_instr,
  output logic [n-1:0] if_pc,
  output logic [n-1:0] if_pc_plus4,
  output logic         halted,
  output logic         misalign_err
);

  import rv_fetch_pkg::*;

  localparam logic [1:0] S_BOOT = BOOT;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_HALT = HALT;

  logic [1:0]   state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic         misalign_err_q, misalign_err_d;
  logic         fire, load, clr;
  logic [n-1:0] pc_plus4;

  assign pc_plus4 = pc_q + n'(PC_INC);
  assign fire     = (state_q == S_RUN) && (!if_valid || id_ready);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    misalign_err_d = 1'b0;
    load           = 1'b0;
    clr            = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        clr     = if_valid && id_ready;
      end
      S_RUN, S_HALT: begin
        if (redirect_valid) begin
          // Flush regardless of id_ready; the target is fetched next cycle.
          pc_d    = redirect_pc & ~n'(3);
          clr     = 1'b1;
          state_d = S_RUN;
`ifdef IFETCH_MISALIGN_CHK_EN
          if (redirect_pc[1:0] != 2'b00) begin
            misalign_err_d = 1'b1;
            state_d        = S_HALT;
          end
`endif
        end else if (halt_req && (state_q == S_RUN)) begin
          state_d = S_HALT;
          clr     = if_valid && id_ready;
        end else if (fire) begin
          load = 1'b1;
          pc_d = pc_plus4;
        end else begin
          clr = if_valid && id_ready;
        end
      end
      default: begin
        state_d = S_BOOT;
        clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_BOOT;
      pc_q           <= n'(RESET_PC);
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  if_id_reg #(
    .W   (n),
    .NOP (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .clr         (clr),
    .instr_in    (imem_rdata),
    .pc_in       (pc_q),
    .pc_plus4_in (pc_plus4),
    .valid       (if_valid),
    .instr       (if_instr),
    .pc          (if_pc),
    .pc_plus4    (if_pc_plus4)
  );

  assign imem_addr    = pc_q;
  assign halted       = (state_q == S_HALT);
  assign misalign_err = misalign_err_q;

endmodule
